// File: rtl/huffman_stream_decoder.sv
`timescale 1ns/1ps
// huffman_stream_decoder
// Table-driven serial Huffman decoder. Bits arrive MSB-first, one per cycle.
// The accumulated prefix is matched against a run-time-loadable codeword
// table. Decoded symbols leave through a registered valid/ready output.
// Prefixes that match nothing within MAX_LEN bits are flagged and counted.
//
// Optional build macro: HUFFMAN_DEFAULT_TABLE_EN. When it is defined, reset
// preloads entries 0..5 with the legacy six-symbol code
// (00->1, 01->2, 10->3, 110->4, 111000->5, 111001->6).
// When it is undefined, every entry resets to len=0 (disabled).
//
// Handshakes:
//   in/in_valid/in_ready     : a bit transfers on a cycle with in_valid & in_ready.
//   sym_out/sym_valid/sym_ready : a symbol transfers on a cycle with
//                              sym_valid & sym_ready. sym_valid stays high and
//                              sym_out stays stable until that transfer.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-low reset
//   in         serial code bit
//   in_valid   in carries a bit this cycle
//   in_ready   decoder can take a bit this cycle
//   cfg_we     table write strobe (also flushes the partial prefix)
//   cfg_idx    table entry index
//   cfg_len    codeword length; 0 disables the entry
//   cfg_code   codeword, right-aligned
//   cfg_sym    symbol value for the entry
//   sym_out    decoded symbol
//   sym_valid  sym_out holds an undelivered symbol
//   sym_ready  consumer accepts sym_out
//   err        one-cycle pulse: no match within MAX_LEN bits
//   err_cnt    saturating count of err events
//   dbg_state  FSM state (0 = IDLE, 1 = ACCUM)
module huffman_stream_decoder #(
  parameter int NUM_SYM = 8,
  parameter int MAX_LEN = 8,
  parameter int SYM_W   = 6,
  localparam int IDX_W  = $clog2(NUM_SYM),
  localparam int LEN_W  = $clog2(MAX_LEN + 1),
  localparam int CNT_W  = $clog2(MAX_LEN)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               cfg_we,
  input  logic [IDX_W-1:0]   cfg_idx,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic [MAX_LEN-1:0] cfg_code,
  input  logic [SYM_W-1:0]   cfg_sym,
  output logic [SYM_W-1:0]   sym_out,
  output logic               sym_valid,
  input  logic               sym_ready,
  output logic               err,
  output logic [15:0]        err_cnt,
  output logic [0:0]         dbg_state
);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_ACCUM = 1'b1;

  logic [LEN_W-1:0]   len_tab  [NUM_SYM];
  logic [MAX_LEN-1:0] code_tab [NUM_SYM];
  logic [SYM_W-1:0]   sym_tab  [NUM_SYM];

  logic [MAX_LEN-1:0] acc;
  logic [CNT_W-1:0]   cnt;

  logic               accept;
  logic [LEN_W-1:0]   l_len;
  logic [MAX_LEN-1:0] cand;
  logic [MAX_LEN-1:0] mask;
  logic               at_max;
  logic               hit;
  logic [SYM_W-1:0]   hit_sym;

  // A table write takes the cycle, so no bit can slip in while the prefix flushes.
  assign in_ready  = (!sym_valid | sym_ready) & !cfg_we;
  assign accept    = in_valid & in_ready;
  assign l_len     = LEN_W'(cnt) + LEN_W'(1);
  // acc only ever holds cnt significant bits; its upper bits stay zero.
  assign cand      = {acc[MAX_LEN-2:0], in};
  assign at_max    = (l_len == LEN_W'(MAX_LEN));
  assign dbg_state = (cnt == '0) ? ST_IDLE : ST_ACCUM;

  always_comb begin
    mask = '0;
    for (int b = 0; b < MAX_LEN; b++) begin
      mask[b] = (b < int'(l_len));
    end
  end

  // Scan from the top index down so the lowest matching index is written last.
  always_comb begin
    hit     = 1'b0;
    hit_sym = '0;
    for (int i = NUM_SYM - 1; i >= 0; i--) begin
      if ((len_tab[i] != '0) && (len_tab[i] == l_len) &&
          (((code_tab[i] ^ cand) & mask) == '0)) begin
        hit     = 1'b1;
        hit_sym = sym_tab[i];
      end
    end
  end

  // Codeword table
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_SYM; i++) begin
        len_tab[i]  <= '0;
        code_tab[i] <= '0;
        sym_tab[i]  <= '0;
      end
`ifdef HUFFMAN_DEFAULT_TABLE_EN
      len_tab[0] <= LEN_W'(2); code_tab[0] <= MAX_LEN'(2'b00);     sym_tab[0] <= SYM_W'(1);
      len_tab[1] <= LEN_W'(2); code_tab[1] <= MAX_LEN'(2'b01);     sym_tab[1] <= SYM_W'(2);
      len_tab[2] <= LEN_W'(2); code_tab[2] <= MAX_LEN'(2'b10);     sym_tab[2] <= SYM_W'(3);
      len_tab[3] <= LEN_W'(3); code_tab[3] <= MAX_LEN'(3'b110);    sym_tab[3] <= SYM_W'(4);
      len_tab[4] <= LEN_W'(6); code_tab[4] <= MAX_LEN'(6'b111000); sym_tab[4] <= SYM_W'(5);
      len_tab[5] <= LEN_W'(6); code_tab[5] <= MAX_LEN'(6'b111001); sym_tab[5] <= SYM_W'(6);
`endif
    end else if (cfg_we && (int'(cfg_idx) < NUM_SYM)) begin
      len_tab[cfg_idx]  <= cfg_len;
      code_tab[cfg_idx] <= cfg_code;
      sym_tab[cfg_idx]  <= cfg_sym;
    end
  end

  // Prefix accumulator, output register and error counter
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc       <= '0;
      cnt       <= '0;
      sym_out   <= '0;
      sym_valid <= 1'b0;
      err       <= 1'b0;
      err_cnt   <= '0;
    end else begin
      err <= 1'b0;
      // Delivery first; a match below in the same cycle re-asserts sym_valid.
      if (sym_valid && sym_ready) begin
        sym_valid <= 1'b0;
      end
      if (cfg_we) begin
        acc <= '0;
        cnt <= '0;
      end else if (accept) begin
        if (hit) begin
          sym_out   <= hit_sym;
          sym_valid <= 1'b1;
          acc       <= '0;
          cnt       <= '0;
        end else if (at_max) begin
          err <= 1'b1;
          acc <= '0;
          cnt <= '0;
          if (err_cnt != 16'hFFFF) begin
            err_cnt <= err_cnt + 16'd1;
          end
        end else begin
          acc <= cand;
          cnt <= CNT_W'(l_len);
        end
      end
    end
  end

endmodule

// File: doc/huffman_stream_decoder.md
# huffman_stream_decoder

Parametrised, table-driven successor to the fixed six-symbol Huffman FSM. It consumes a serial bitstream MSB-first, one bit per cycle, and matches the accumulated prefix against a run-time-loadable table of up to NUM_SYM codewords of length 1..MAX_LEN. It emits decoded symbols on a valid/ready output and flags and counts undecodable prefixes. It sits between the serial bit source and the symbol consumer.

## Interface
- NUM_SYM, 8, number of table entries (2..32)
- MAX_LEN, 8, maximum codeword length in bits (2..16)
- SYM_W, 6, symbol width
- clk  input  1  clock, rising edge
- rst  input  1  asynchronous, active-low reset: asserting it resets the block immediately, without waiting for a clock edge
- in  input  1  serial code bit; the first bit of each codeword arrives first
- in_valid  input  1  in is valid this cycle
- in_ready  output  1  bit accepted when in_valid & in_ready
- cfg_we  input  1  table write strobe
- cfg_idx  input  $clog2(NUM_SYM)  entry index
- cfg_len  input  $clog2(MAX_LEN+1)  codeword length; 0 disables the entry
- cfg_code  input  MAX_LEN  codeword, right-aligned (low cfg_len bits used)
- cfg_sym  input  SYM_W  symbol value for the entry
- sym_out  output  SYM_W  decoded symbol
- sym_valid  output  1  sym_out holds an undelivered symbol
- sym_ready  input  1  consumer accepts sym_out
- err  output  1  one-cycle pulse: no match within MAX_LEN bits
- err_cnt  output  16  saturating count of err events

## Operation
- State: accumulator acc[MAX_LEN-1:0] and bit count cnt (0..MAX_LEN-1). FSM states are IDLE (cnt==0) and ACCUM (cnt>0). Output register holds sym_out/sym_valid.
- in_ready = (!sym_valid | sym_ready) & !cfg_we.
- On an accepted bit, form cand = {acc, in} of length L = cnt+1.
- Entry i matches iff len_i != 0, len_i == L, and the low L bits of code_i equal cand. With multiple matches, the lowest index wins.
- On a match: sym_out <= sym_i, sym_valid <= 1, cnt <= 0, acc <= 0 (return to IDLE).
- No match and L < MAX_LEN: acc <= cand, cnt <= L (ACCUM).
- No match and L == MAX_LEN: err pulses, err_cnt increments, saturating at 16'hFFFF. acc and cnt clear. No symbol is emitted.
- sym_valid clears on sym_valid & sym_ready unless a new match loads it in the same cycle. A simultaneous deliver-and-load keeps sym_valid=1 with the new symbol.
- cfg_we writes entry cfg_idx on the clock edge and flushes acc/cnt to IDLE. The output register and err_cnt are unaffected. in_ready is 0 during cfg_we, so no bit is lost silently.
- Table contents are not checked for prefix-freeness; overlaps resolve by length (shorter codes match first) and then by index.

## Timing
- Reset values: in_ready=1 (after release), sym_valid=0, sym_out=0, err=0, err_cnt=0, acc=0, cnt=0. All table len=0 unless the macro below is defined.
- Latency: sym_valid rises on the clock edge that accepts the final bit of a codeword, i.e. it is visible the cycle after that bit.
- Throughput: one bit per cycle, with no bubbles while sym_ready=1. A 1-bit code can yield one symbol per cycle.
- Backpressure: when sym_valid=1 and sym_ready=0, in_ready=0 and acc is held.
- err is asserted for exactly one cycle, registered, the cycle after the MAX_LEN-th unmatched bit.
- Reset mid-codeword discards the partial prefix and any pending symbol.

## Configuration
- HUFFMAN_DEFAULT_TABLE_EN defined: reset loads entries 0..5 as 00→1, 01→2, 10→3, 110→4, 111000→5, 111001→6. Remaining entries get len=0. This requires NUM_SYM≥6, MAX_LEN≥6 and SYM_W≥3.
- HUFFMAN_DEFAULT_TABLE_EN undefined: all entries reset to len=0. The table must be loaded via cfg before decoding, and bits received before loading produce err after MAX_LEN bits.

## Test plan
- Default table, sym_ready=1, stream 00 01 10 110 111000 111001 → sym_out 1,2,3,4,5,6, each valid the cycle after its last bit.
- Default table, stream 11110000 (MAX_LEN=8) → err pulses once after bit 8, err_cnt=1, no sym_valid; the next stream 00 → symbol 1.
- sym_ready=0 after a decode of 00 → sym_valid holds 1, in_ready=0, sym_out stays 1. Raise sym_ready with bit stream 01 pending → 2 delivered with no lost bits.
- Write entry 0 as len=1, code 0, sym=9 mid-codeword (after bit 1) → prefix flushed, in_ready=0 that cycle; subsequent bit 0 → sym_out=9.
- Overlapping entries idx2 {len 2, code 10, sym 7} and idx5 {len 2, code 10, sym 8} → stream 10 yields 7.
- Assert rst for 1 ns between clock edges during ACCUM with sym_valid=1 → all outputs take reset values immediately; err_cnt=0.
